conv3x3_ctrl: RTL and testbench

Sequencer for the convolution accelerator. It starts on the start pulse from the memory-mapped config register block and loads the 3x3 weights. It then walks the output feature map in raster order, fetching input pixels and accumulating, and writes one output word per pixel to data memory. It reports idle/done back to the config block's status register and is the only accelerator master on the shared dmem port.

---
 rtl/conv3x3_ctrl_if.sv | 41 ++++
 rtl/conv3x3_ctrl.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_conv3x3_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv3x3_ctrl_if.sv
// Memory port bundle for the convolution sequencer.
// The controller is the master (request side); data memory or its arbiter is
// the slave.
//   mem_req    request valid, held until mem_ready
//   mem_we     1 = write, 0 = read
//   mem_addr   byte address, word aligned
//   mem_wdata  write data
//   mem_ready  request accepted this cycle
//   mem_rvalid read data valid (one cycle per accepted read)
//   mem_rdata  read data
interface conv3x3_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/conv3x3_ctrl.sv
// 3x3 same-size convolution sequencer.
// On start it loads nine weights, then walks the NxN output map in raster
// order. For each output pixel it reads the in-bounds input taps and
// multiply-accumulates them, then writes one output word. Out-of-bounds taps
// are zero padding and cost one cycle with no memory traffic.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active low
//   start_i       one-cycle start pulse, ignored while busy
//   fm_dim_i      feature-map side N (low DIM_W bits used)
//   ifm_offset_i  input map base byte address
//   wt_offset_i   weight base byte address
//   ofm_offset_i  output map base byte address
//   idle_o        high in IDLE or DONE
//   done_o        sticky completion flag, cleared by the next start
//   mem           memory master port (see conv3x3_ctrl_if)
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start
// LD_WT   | fetching w[0..8], one outstanding read at a time
// RD_IFM  | evaluate tap k: issue read, or skip if in the padding
// WAIT_RD | read pending: waiting for accept, then for rvalid
// MAC     | acc += w[k] * pixel
// WR_OFM  | write acc for the current output pixel
// DONE    | run finished, done_o held until the next start
module conv3x3_ctrl #(
    parameter int DIM_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] fm_dim_i,
    input  logic [31:0] ifm_offset_i,
    input  logic [31:0] wt_offset_i,
    input  logic [31:0] ofm_offset_i,
    output logic        idle_o,
    output logic        done_o,
    conv3x3_ctrl_if.master mem
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_WT,
        S_RD_IFM,
        S_WAIT_RD,
        S_MAC,
        S_WR_OFM,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DIM_W-1:0] n_r;
    logic [DIM_W-1:0] x_r;
    logic [DIM_W-1:0] y_r;
    logic [31:0]      ifm_off_r;
    logic [31:0]      wt_off_r;
    logic [31:0]      ofm_off_r;
    logic [3:0]       k_r;
    logic [31:0]      acc_r;
    logic [31:0]      pix_r;
    logic [31:0]      w_r [0:8];
    logic             rd_wait_r;

    logic [1:0]         ky;
    logic [1:0]         kx;
    logic [DIM_W:0]     yk;
    logic [DIM_W:0]     xk;
    logic [DIM_W-1:0]   iy;
    logic [DIM_W-1:0]   ix;
    logic [2*DIM_W-1:0] ifm_prod;
    logic [2*DIM_W-1:0] ofm_prod;
    logic [31:0]        ifm_idx;
    logic [31:0]        ofm_idx;
    logic [31:0]        ifm_addr;
    logic [31:0]        wt_addr;
    logic [31:0]        ofm_addr;
    logic               tap_valid;
    logic               last_k;
    logic               last_x;
    logic               last_px;
    logic               dim_zero;
    logic               req_accept;
    logic               unused_bits;

    // Split k into kernel row/column.
    always_comb begin
        ky = 2'd0;
        kx = 2'd0;
        case (k_r)
            4'd0: begin ky = 2'd0; kx = 2'd0; end
            4'd1: begin ky = 2'd0; kx = 2'd1; end
            4'd2: begin ky = 2'd0; kx = 2'd2; end
            4'd3: begin ky = 2'd1; kx = 2'd0; end
            4'd4: begin ky = 2'd1; kx = 2'd1; end
            4'd5: begin ky = 2'd1; kx = 2'd2; end
            4'd6: begin ky = 2'd2; kx = 2'd0; end
            4'd7: begin ky = 2'd2; kx = 2'd1; end
            4'd8: begin ky = 2'd2; kx = 2'd2; end
            default: begin ky = 2'd0; kx = 2'd0; end
        endcase
    end

    // yk/xk are the input coordinate plus one, so the -1 padding row/column
    // shows up as 0 and the +N one as N+1 without going negative.
    assign yk = {1'b0, y_r} + (DIM_W+1)'(ky);
    assign xk = {1'b0, x_r} + (DIM_W+1)'(kx);
    assign iy = DIM_W'(yk - (DIM_W+1)'(1));
    assign ix = DIM_W'(xk - (DIM_W+1)'(1));

    assign tap_valid = (yk != '0) && (yk <= {1'b0, n_r}) &&
                       (xk != '0) && (xk <= {1'b0, n_r});

    assign ifm_prod = {{DIM_W{1'b0}}, iy}  * {{DIM_W{1'b0}}, n_r};
    assign ofm_prod = {{DIM_W{1'b0}}, y_r} * {{DIM_W{1'b0}}, n_r};
    assign ifm_idx  = 32'(ifm_prod) + 32'(ix);
    assign ofm_idx  = 32'(ofm_prod) + 32'(x_r);
    assign ifm_addr = ifm_off_r + {ifm_idx[29:0], 2'b00};
    assign ofm_addr = ofm_off_r + {ofm_idx[29:0], 2'b00};
    assign wt_addr  = wt_off_r + {26'd0, k_r, 2'b00};

    assign last_k     = (k_r == 4'd8);
    assign last_x     = (x_r == n_r - DIM_W'(1));
    assign last_px    = last_x && (y_r == n_r - DIM_W'(1));
    assign dim_zero   = (fm_dim_i[DIM_W-1:0] == '0);
    assign req_accept = mem.mem_req && mem.mem_ready;

    assign unused_bits = ^{fm_dim_i[31:DIM_W], ifm_idx[31:30], ofm_idx[31:30]};

    assign idle_o = (state == S_IDLE) || (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_nxt = dim_zero ? S_DONE : S_LD_WT;
                end
            end
            S_LD_WT: begin
                if (rd_wait_r && mem.mem_rvalid && last_k) begin
                    state_nxt = S_RD_IFM;
                end
            end
            S_RD_IFM: begin
                if (tap_valid) begin
                    state_nxt = S_WAIT_RD;
                end else if (last_k) begin
                    state_nxt = S_WR_OFM;
                end
            end
            S_WAIT_RD: begin
                // mem_req low here means the read was already accepted
                if (!mem.mem_req && mem.mem_rvalid) begin
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                state_nxt = last_k ? S_WR_OFM : S_RD_IFM;
            end
            S_WR_OFM: begin
                if (req_accept) begin
                    state_nxt = last_px ? S_DONE : S_RD_IFM;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_r           <= '0;
            x_r           <= '0;
            y_r           <= '0;
            ifm_off_r     <= '0;
            wt_off_r      <= '0;
            ofm_off_r     <= '0;
            k_r           <= '0;
            acc_r         <= '0;
            pix_r         <= '0;
            rd_wait_r     <= 1'b0;
            done_o        <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            for (int i = 0; i < 9; i++) begin
                w_r[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        n_r       <= fm_dim_i[DIM_W-1:0];
                        ifm_off_r <= ifm_offset_i;
                        wt_off_r  <= wt_offset_i;
                        ofm_off_r <= ofm_offset_i;
                        k_r       <= '0;
                        done_o    <= dim_zero;
                    end
                end
                S_LD_WT: begin
                    if (!mem.mem_req && !rd_wait_r) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= ADDR_W'(wt_addr);
                    end else if (req_accept) begin
                        mem.mem_req <= 1'b0;
                        rd_wait_r   <= 1'b1;
                    end else if (rd_wait_r && mem.mem_rvalid) begin
                        w_r[k_r]  <= mem.mem_rdata;
                        rd_wait_r <= 1'b0;
                        if (last_k) begin
                            k_r   <= '0;
                            x_r   <= '0;
                            y_r   <= '0;
                            acc_r <= '0;
                        end else begin
                            k_r <= k_r + 4'd1;
                        end
                    end
                end
                S_RD_IFM: begin
                    if (tap_valid) begin
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= ADDR_W'(ifm_addr);
                    end else if (!last_k) begin
                        k_r <= k_r + 4'd1;
                    end
                end
                S_WAIT_RD: begin
                    if (mem.mem_req) begin
                        if (mem.mem_ready) begin
                            mem.mem_req <= 1'b0;
                        end
                    end else if (mem.mem_rvalid) begin
                        pix_r <= mem.mem_rdata;
                    end
                end
                S_MAC: begin
                    acc_r <= acc_r + w_r[k_r] * pix_r;
                    if (!last_k) begin
                        k_r <= k_r + 4'd1;
                    end
                end
                S_WR_OFM: begin
                    if (!mem.mem_req) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= ADDR_W'(ofm_addr);
                        mem.mem_wdata <= acc_r;
                    end else if (mem.mem_ready) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        acc_r       <= '0;
                        k_r         <= '0;
                        if (last_px) begin
                            done_o <= 1'b1;
                        end else if (last_x) begin
                            x_r <= '0;
                            y_r <= y_r + DIM_W'(1);
                        end else begin
                            x_r <= x_r + DIM_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_ctrl.sv
module tb_conv3x3_ctrl;

    localparam bit [31:0] WO = 32'h0000_0100;
    localparam bit [31:0] IO = 32'h0000_1000;
    localparam bit [31:0] OO = 32'h0000_2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] fm_dim_i;
    logic [31:0] ifm_offset_i;
    logic [31:0] wt_offset_i;
    logic [31:0] ofm_offset_i;
    logic        idle_o;
    logic        done_o;

    conv3x3_ctrl_if #(.ADDR_W(32)) mem_bus ();

    conv3x3_ctrl #(.DIM_W(16), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .fm_dim_i     (fm_dim_i),
        .ifm_offset_i (ifm_offset_i),
        .wt_offset_i  (wt_offset_i),
        .ofm_offset_i (ofm_offset_i),
        .idle_o       (idle_o),
        .done_o       (done_o),
        .mem          (mem_bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- memory slave model ----------------
    bit [31:0] mem_words [bit [31:0]];
    bit        rand_ready = 1'b0;
    int        lat_min = 1;
    int        lat_max = 1;
    int        rd_count = 0;
    int        rd_cnt_down = 0;
    bit [31:0] rd_data_pend;
    bit [31:0] last_rd_addr;
    bit [31:0] wr_addr_q [$];
    bit [31:0] wr_data_q [$];
    int        req_seen = 0;
    bit        prev_stall = 1'b0;
    bit        prev_we;
    bit [31:0] prev_addr;
    bit [31:0] prev_wdata;

    // Inputs change on the falling edge; acceptance for the next rising edge
    // is known here because mem_req and mem_ready are both stable until then.
    always @(negedge clk) begin
        mem_bus.mem_rvalid = 1'b0;
        if (rd_cnt_down > 0) begin
            rd_cnt_down--;
            if (rd_cnt_down == 0) begin
                mem_bus.mem_rvalid = 1'b1;
                mem_bus.mem_rdata  = rd_data_pend;
            end
        end
        if (rst !== 1'b1) begin
            prev_stall = 1'b0;
        end else if (prev_stall) begin
            check("stall_ctl", {30'd0, mem_bus.mem_req, mem_bus.mem_we}, {30'd0, 1'b1, prev_we});
            check("stall_addr", mem_bus.mem_addr, prev_addr);
            check("stall_wdata", mem_bus.mem_wdata, prev_wdata);
        end
        if (rst === 1'b1 && mem_bus.mem_req === 1'b1) req_seen++;
        mem_bus.mem_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (rst === 1'b1 && mem_bus.mem_req === 1'b1 && mem_bus.mem_ready) begin
            if (mem_bus.mem_we) begin
                wr_addr_q.push_back(mem_bus.mem_addr);
                wr_data_q.push_back(mem_bus.mem_wdata);
            end else begin
                rd_count++;
                last_rd_addr = mem_bus.mem_addr;
                rd_data_pend = mem_words.exists(mem_bus.mem_addr) ?
                               mem_words[mem_bus.mem_addr] : 32'hDEAD_BEEF;
                rd_cnt_down  = int'($urandom_range(lat_min, lat_max));
            end
        end
        prev_stall = (rst === 1'b1) && (mem_bus.mem_req === 1'b1) && !mem_bus.mem_ready;
        prev_we    = mem_bus.mem_we;
        prev_addr  = mem_bus.mem_addr;
        prev_wdata = mem_bus.mem_wdata;
    end

    // ---------------- reference model data ----------------
    bit [31:0] wt_arr  [9];
    bit [31:0] ifm_arr [64];

    task automatic load_case(input int n, input bit [31:0] wo, input bit [31:0] io);
        mem_words.delete();
        for (int k = 0; k < 9; k++) mem_words[wo + 32'(4 * k)] = wt_arr[k];
        for (int i = 0; i < n * n; i++) mem_words[io + 32'(4 * i)] = ifm_arr[i];
        rd_count = 0;
        req_seen = 0;
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic do_start(input int n, input bit [31:0] wo, input bit [31:0] io,
                            input bit [31:0] oo);
        fm_dim_i     = n;
        wt_offset_i  = wo;
        ifm_offset_i = io;
        ofm_offset_i = oo;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
        check("start_done", {31'd0, done_o}, (n == 0) ? 32'd1 : 32'd0);
        check("start_idle", {31'd0, idle_o}, (n == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done_o !== 1'b1 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_finish"}, {31'd0, done_o}, 32'd1);
    endtask

    // Direct evaluation of the zero-padded 3x3 convolution.
    task automatic check_results(input string tag, input int n, input bit [31:0] oo);
        bit [31:0] exp_q [$];
        int taps = 0;
        for (int y = 0; y < n; y++) begin
            for (int x = 0; x < n; x++) begin
                bit [31:0] s = 32'd0;
                for (int ky = 0; ky < 3; ky++) begin
                    for (int kx = 0; kx < 3; kx++) begin
                        int iy = y + ky - 1;
                        int ix = x + kx - 1;
                        if (iy >= 0 && iy < n && ix >= 0 && ix < n) begin
                            s = s + wt_arr[ky * 3 + kx] * ifm_arr[iy * n + ix];
                            taps++;
                        end
                    end
                end
                exp_q.push_back(s);
            end
        end
        check({tag, "_nwr"}, wr_addr_q.size(), n * n);
        for (int i = 0; i < n * n; i++) begin
            if (i < wr_addr_q.size()) begin
                check($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[i], oo + 32'(4 * i));
                check($sformatf("%s_wr%0d_data", tag, i), wr_data_q[i], exp_q[i]);
            end
        end
        check({tag, "_nrd"}, rd_count, 9 + taps);
        check({tag, "_idle"}, {31'd0, idle_o}, 32'd1);
        check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        int cyc;
        rst          = 1'b0;
        start_i      = 1'b0;
        fm_dim_i     = '0;
        ifm_offset_i = '0;
        wt_offset_i  = '0;
        ofm_offset_i = '0;
        mem_bus.mem_ready  = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = '0;

        repeat (3) @(negedge clk);
        check("rst_idle", {31'd0, idle_o}, 32'd1);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_bus.mem_we}, 32'd0);
        check("rst_addr", mem_bus.mem_addr, 32'd0);
        check("rst_wdata", mem_bus.mem_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // N=1, single centre tap
        for (int k = 0; k < 9; k++) wt_arr[k] = 32'd0;
        wt_arr[4] = 32'd3;
        ifm_arr[0] = 32'd5;
        load_case(1, WO, IO);
        do_start(1, WO, IO, OO);
        wait_done("n1");
        check_results("n1", 1, OO);
        check("n1_val", wr_data_q[0], 32'd15);

        // N=2, all ones
        for (int k = 0; k < 9; k++) wt_arr[k] = 32'd1;
        for (int i = 0; i < 4; i++) ifm_arr[i] = 32'd1;
        load_case(2, WO, IO);
        do_start(2, WO, IO, OO);
        wait_done("n2");
        check_results("n2", 2, OO);
        check("n2_nrd_abs", rd_count, 32'd25);

        // N=3 identity kernel, then box filter
        for (int k = 0; k < 9; k++) wt_arr[k] = 32'd0;
        wt_arr[4] = 32'd1;
        for (int i = 0; i < 9; i++) ifm_arr[i] = 32'(i + 1);
        load_case(3, WO, IO);
        do_start(3, WO, IO, OO);
        wait_done("n3id");
        check_results("n3id", 3, OO);
        for (int k = 0; k < 9; k++) wt_arr[k] = 32'd1;
        load_case(3, WO, IO);
        do_start(3, WO, IO, OO);
        wait_done("n3box");
        check_results("n3box", 3, OO);
        check("n3box_corner", wr_data_q[0], 32'd12);
        check("n3box_centre", wr_data_q[4], 32'd45);

        // N=2 with random back-pressure and read latency
        rand_ready = 1'b1;
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 4; i++) ifm_arr[i] = 32'd1;
        load_case(2, WO, IO);
        do_start(2, WO, IO, OO);
        wait_done("n2rnd");
        check_results("n2rnd", 2, OO);

        // N=4 random data, wrapping arithmetic
        for (int k = 0; k < 9; k++) wt_arr[k] = $urandom();
        for (int i = 0; i < 16; i++) ifm_arr[i] = $urandom();
        load_case(4, 32'h0000_0400, 32'h0000_3000);
        do_start(4, 32'h0000_0400, 32'h0000_3000, 32'h0000_4000);
        wait_done("n4rnd");
        check_results("n4rnd", 4, 32'h0000_4000);

        // Start and config changes while busy must not disturb the run
        for (int k = 0; k < 9; k++) wt_arr[k] = $urandom_range(0, 255);
        for (int i = 0; i < 9; i++) ifm_arr[i] = $urandom_range(0, 255);
        load_case(3, WO, IO);
        do_start(3, WO, IO, OO);
        repeat (30) @(negedge clk);
        fm_dim_i     = 32'd1;
        wt_offset_i  = 32'h0000_0300;
        ifm_offset_i = 32'h0000_5000;
        ofm_offset_i = 32'h0000_6000;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
        check("midrun_busy", {31'd0, idle_o}, 32'd0);
        wait_done("midrun");
        check_results("midrun", 3, OO);

        // N=0 completes immediately without memory traffic
        load_case(0, WO, IO);
        do_start(0, WO, IO, OO);
        repeat (5) @(negedge clk);
        check("n0_noreq", req_seen, 32'd0);
        check("n0_done_hold", {31'd0, done_o}, 32'd1);

        // Reset while a pixel read is outstanding
        rand_ready = 1'b0;
        lat_min = 4;
        lat_max = 4;
        for (int k = 0; k < 9; k++) wt_arr[k] = 32'd1;
        for (int i = 0; i < 4; i++) ifm_arr[i] = 32'd1;
        load_case(2, WO, IO);
        do_start(2, WO, IO, OO);
        cyc = 0;
        while (!(rd_cnt_down >= 2 && last_rd_addr >= IO && last_rd_addr < IO + 32'd16)
               && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_wait_reached", (cyc < 500) ? 32'd1 : 32'd0, 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_idle", {31'd0, idle_o}, 32'd1);
        check("arst_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check("arst_done", {31'd0, done_o}, 32'd0);
        check("arst_addr", mem_bus.mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("late_rv_idle", {31'd0, idle_o}, 32'd1);
        check("late_rv_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check("late_rv_done", {31'd0, done_o}, 32'd0);

        rand_ready = 1'b1;
        lat_min = 1;
        lat_max = 4;
        load_case(2, WO, IO);
        do_start(2, WO, IO, OO);
        wait_done("rerun");
        check_results("rerun", 2, OO);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
